// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, byte type and baud timing.
package uart_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  localparam int CLOCKS_PER_BAUD = 16;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester bus plus transmitter handshake seen by the UART TX arbiter.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) ();

  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] data;
  logic [NREQ-1:0]   lock;
  logic [NREQ-1:0]   ack;
  logic              tx_wr;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic [IDW-1:0]    grant_id;
  logic              locked;

  // Producers and transmitter side
  modport master (
    output req, data, lock, tx_busy,
    input  ack, tx_wr, tx_data, grant_id, locked
  );

  // Arbiter side
  modport slave (
    input  req, data, lock, tx_busy,
    output ack, tx_wr, tx_data, grant_id, locked
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first request strictly after ptr wins,
// wrapping around so ptr itself has lowest priority.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int c;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    for (int i = 1; i <= N; i++) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      if (!any && req[c[IW-1:0]]) begin
        any               = 1'b1;
        grant[c[IW-1:0]]  = 1'b1;
        idx               = c[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers,
// with per-requester lock so multi-byte messages are never interleaved.
//
// state | meaning
// IDLE  | no byte in flight; issue when tx idle and someone eligible
// SEND  | tx_wr/ack pulse for the selected byte
// WAIT  | wait for the transmitter to drop busy
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic i_clk,
  input logic i_reset_n,
  uart_tx_arbiter_if.slave bus
);

  arb_state_t      state;
  logic            tx_wr;
  byte_t           tx_data;
  logic [NREQ-1:0] ack;
  logic [IDW-1:0]  grant_id;
  logic            locked;

  logic [NREQ-1:0] own_mask;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] pick_grant;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  byte_t           pick_byte;
  logic            lock_owner;

  always_comb begin
    own_mask           = '0;
    own_mask[grant_id] = 1'b1;
  end

  // While locked only the owner may issue; other requesters wait indefinitely.
  assign eligible   = locked ? (bus.req & own_mask) : bus.req;
  assign lock_owner = bus.lock[grant_id];

  rr_pick #(.N(NREQ), .IW(IDW)) u_pick (
    .req   (eligible),
    .ptr   (grant_id),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    pick_byte = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick_grant[k]) pick_byte = bus.data[8*k +: 8];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      tx_wr    <= 1'b0;
      tx_data  <= '0;
      ack      <= '0;
      grant_id <= IDW'(NREQ - 1);
      locked   <= 1'b0;
    end else begin
      tx_wr <= 1'b0;
      ack   <= '0;
      if (!lock_owner) locked <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!bus.tx_busy && pick_any) begin
            state    <= SEND;
            tx_wr    <= 1'b1;
            ack      <= pick_grant;
            tx_data  <= pick_byte;
            grant_id <= pick_idx;
            locked   <= bus.lock[pick_idx];
          end
        end
        SEND: state <= WAIT;
        WAIT: begin
          if (!bus.tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_wr    = tx_wr;
  assign bus.tx_data  = tx_data;
  assign bus.ack      = ack;
  assign bus.grant_id = grant_id;
  assign bus.locked   = locked;

endmodule
